// File: rtl/cpu_out_fifo.sv
// cpu_out_fifo: gated capture of CPU output words into a FIFO,
// delivered over a valid/ready handshake with run/drain sequencing.
module cpu_out_fifo #(
    parameter int WIDTH        = 36,
    parameter int DEPTH        = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int CNTWIDTH     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    startIO,
    input  logic                    outFlag,
    input  logic [WIDTH-1:0]        out,
    input  logic                    clear,
    input  logic                    rdReady,
    output logic                    rdValid,
    output logic [WIDTH-1:0]        rdData,
    output logic [ADDRESSWIDTH:0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [CNTWIDTH-1:0]     dropCount,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDRESSWIDTH:0] FULL_CNT = (ADDRESSWIDTH+1)'(DEPTH);
    localparam logic [CNTWIDTH-1:0]   DROP_MAX = '1;

    state_t                  state_q;
    logic [ADDRESSWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESSWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESSWIDTH:0]   count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [CNTWIDTH-1:0]     drop_q, drop_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];

    logic full_w;
    logic empty_w;
    logic push_req;
    logic push;
    logic pop;
    logic drop;

    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);

    // Handshake qualification; clear overrides both push and pop
    always_comb begin
        pop      = !empty_w && rdReady && !clear;
        push_req = (state_q == RUN) && outFlag && !clear;
        push     = push_req && (!full_w || pop);
        drop     = push_req && full_w && !pop;
    end

    // Next-state values for pointers, occupancy and drop accounting
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != DROP_MAX) begin
                    drop_d = drop_q + 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Run/drain sequencer; drain ends once occupancy hits zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= startIO ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (startIO) state_q <= RUN;
                end
                RUN: begin
                    if (!startIO) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (startIO) begin
                        state_q <= RUN;
                    end else if (count_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out;
        end
    end

    assign rdValid   = !empty_w;
    assign rdData    = empty_w ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = overflow_q;
    assign dropCount = drop_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);

endmodule
